mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide responder that owns the architectural HI/LO register pair for the pipelined MIPS core.
- Sits beside the single-cycle ALU in EX. The pipeline initiates an operation with a start pulse, stalls on busy, and reads hi/lo through the MFHI/MFLO path.
- Uses iterative radix-2 datapaths (shift-add multiply, restoring divide), so there is no large combinational multiplier or divider.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration cycles per mul/div; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe, sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; other codes are no-ops.
- a  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  32  rt operand: multiplier or divisor.
- flush  in  1  aborts the in-flight operation.
- busy  out  1  operation in flight; the pipeline must stall MFHI/MFLO and further mul/div while high.
- done  out  1  one-cycle pulse in the cycle the new hi/lo become visible.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0. A reset mid-operation discards all partial results.
- States:
  - IDLE.
  - CALC: ITER cycles, counter 0..ITER-1.
  - FIX: 1 cycle for sign correction and write-back.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch operands. For signed ops, store absolute values plus the result-sign flags.
  - Next state CALC; busy=1 from the following cycle.
- IDLE, start=1, op=MTHI or MTLO: hi (resp. lo) <= a at that edge. busy stays 0 and done stays 0.
- IDLE, start=1, undefined op: ignored.
- CALC, multiply:
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit accumulator.
  - Then shift the accumulator right by 1, keeping the carry.
- CALC, divide (restoring):
  - Shift the remainder:quotient pair left 1.
  - Trial-subtract the divisor; if the result is non-negative, keep it and set quotient bit 1.
- FIX:
  - Negate the product if sign(a) XOR sign(b).
  - Negate the quotient if the signs differ.
  - Give the remainder the sign of the dividend.
  - Write hi/lo at the FIX->IDLE edge: hi=upper/remainder, lo=lower/quotient.
  - done=1 for exactly that one following cycle; busy=0 in the same cycle.
- Latency:
  - Start accepted at edge E0; busy high for ITER+1 = 33 cycles.
  - New hi/lo and done are visible in the cycle after edge E0+33.
- Divide by zero: lo=32'hFFFFFFFF, hi=a (unmodified dividend), for both signed and unsigned. Latency is normal and done is pulsed.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- start while busy: ignored, including MTHI/MTLO. The pipeline is responsible for stalling.
- flush while busy:
  - Next state IDLE, busy=0, no done pulse, hi/lo unchanged.
  - flush together with start in IDLE: start is ignored.
- flush and rst together: rst wins.
- hi/lo change only at write-back, at MTHI/MTLO, or on reset. They are stable and readable at all other times.

Test Plan:
1. Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles; then done pulse, hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2.
4. DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678, done after normal latency. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. MTHI a=0xDEADBEEF -> hi=0xDEADBEEF next cycle, busy/done never high. Start MULTU 5*6, assert flush at CALC cycle 10 -> busy drops next cycle, no done, hi=0xDEADBEEF retained. A second start pulsed mid-operation is ignored.
6. Start DIVU 9/3, assert rst at CALC cycle 20 -> next cycle hi=lo=0, busy=0, done=0. A fresh MULTU 3*4 then completes normally with lo=12, hi=0.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// ============================================================================
// mul_div_unit_if : request/result bundle between EX stage and mul_div_unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative radix-2 multiply/divide unit owning the HI/LO pair
// Revision 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input wire logic      clk,
    input wire logic      rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;      // mul: {upper, lower/multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_zero;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    always_comb begin
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        abs_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Shift-add step keeps the adder carry as the new MSB after the shift.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};

        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end

        prod_fixed = neg_lo ? -acc : acc;
        quo_fixed  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                acc      <= {{WIDTH{1'b0}}, abs_b};
                                opnd     <= abs_a;
                                is_div   <= 1'b0;
                                neg_lo   <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_hi   <= 1'b0;
                                div_zero <= 1'b0;
                                count    <= '0;
                                bus.busy <= 1'b1;
                                state    <= CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc      <= {{WIDTH{1'b0}}, abs_a};
                                opnd     <= abs_b;
                                a_raw    <= bus.a;
                                is_div   <= 1'b1;
                                neg_lo   <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_hi   <= signed_op && bus.a[WIDTH-1];
                                div_zero <= (bus.b == '0);
                                count    <= '0;
                                bus.busy <= 1'b1;
                                state    <= CALC;
                            end
                            OP_MTHI: bus.hi <= bus.a;
                            OP_MTLO: bus.lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (count == CW'(ITER - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                    if (!bus.flush) begin
                        bus.done <= 1'b1;
                        if (!is_div) begin
                            bus.hi <= prod_fixed[2*WIDTH-1:WIDTH];
                            bus.lo <= prod_fixed[WIDTH-1:0];
                        end else if (div_zero) begin
                            // Divide by zero reports the untouched dividend and an all-ones quotient.
                            bus.hi <= a_raw;
                            bus.lo <= '1;
                        end else begin
                            bus.hi <= rem_fixed;
                            bus.lo <= quo_fixed;
                        end
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
